// File: rtl/k_aud_cmprs_pkg.sv
// ---------------------------------------------------------------------------
// k_aud_cmprs_pkg
// Shared definitions for the audio compressor datapath.
//   env_state_t   : sequencing state of the energy envelope follower
//   K_E_WIDTH     : default energy / envelope width (shared with the
//                   energy computer, re^2 + im^2)
//   K_SHIFT_WIDTH : default width of the attack / release shift controls
// ---------------------------------------------------------------------------
package k_aud_cmprs_pkg;

  localparam int K_E_WIDTH     = 40;
  localparam int K_SHIFT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIFF   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } env_state_t;

endpackage : k_aud_cmprs_pkg

// File: rtl/k_env_step.sv
// ---------------------------------------------------------------------------
// k_env_step
// Combinational step generator for one-pole shift filters:
//   step = diff >> shift, forced to 1 when diff is non-zero but the shift
//   would truncate it to 0, so the filter always converges.
// Ports:
//   diff  in  E_WIDTH      unsigned distance between target and state
//   shift in  SHIFT_WIDTH  coefficient exponent
//   step  out E_WIDTH      amount to move the filter state by
// ---------------------------------------------------------------------------
module k_env_step
  import k_aud_cmprs_pkg::*;
#(
  parameter int E_WIDTH     = K_E_WIDTH,
  parameter int SHIFT_WIDTH = K_SHIFT_WIDTH
) (
  input  logic [E_WIDTH-1:0]     diff,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [E_WIDTH-1:0]     step
);

  logic [E_WIDTH-1:0] shifted;

  // Shift amounts at or beyond E_WIDTH yield 0 and fall into the min-step case.
  assign shifted = diff >> shift;
  assign step    = ((diff != '0) && (shifted == '0)) ? E_WIDTH'(1) : shifted;

endmodule : k_env_step

// File: rtl/k_energy_envelope.sv
// ---------------------------------------------------------------------------
// k_energy_envelope
// Attack/release envelope follower on the per-sample energy stream. One
// sample is processed every 4 cycles: accept -> DIFF -> UPDATE -> DONE.
// The refreshed envelope and its valid pulse appear 3 edges after accept.
// Optional build macro: K_ENV_PEAK_HOLD_EN adds a peak-hold counter that
// freezes release for HOLD_SAMPLES samples after each attack update.
// Ports:
//   clk           in   single clock, rising edge
//   aresetn       in   asynchronous active-low reset
//   in_energy     in   unsigned energy sample
//   in_valid      in   one-cycle qualifier for in_energy
//   attack_shift  in   attack exponent (step = diff >> attack_shift)
//   release_shift in   release exponent
//   out_env       out  registered envelope
//   out_valid     out  one-cycle pulse when out_env was just refreshed
//   busy          out  a sample is in flight
//   overrun       out  sticky: a sample arrived while busy and was dropped
// ---------------------------------------------------------------------------
module k_energy_envelope
  import k_aud_cmprs_pkg::*;
#(
  parameter int E_WIDTH      = K_E_WIDTH,
  parameter int SHIFT_WIDTH  = K_SHIFT_WIDTH,
  parameter int HOLD_SAMPLES = 64
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [E_WIDTH-1:0]     in_energy,
  input  logic                   in_valid,
  input  logic [SHIFT_WIDTH-1:0] attack_shift,
  input  logic [SHIFT_WIDTH-1:0] release_shift,
  output logic [E_WIDTH-1:0]     out_env,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun
);

  env_state_t state_q, state_d;

  logic [E_WIDTH-1:0]     e_p0;
  logic [SHIFT_WIDTH-1:0] ash_p0, rsh_p0;
  logic                   up_p1;
  logic [E_WIDTH-1:0]     diff_p1;
  logic [E_WIDTH-1:0]     env_q;
  logic [E_WIDTH-1:0]     env_upd;
  logic [SHIFT_WIDTH-1:0] shift_sel;
  logic [E_WIDTH-1:0]     step;
  logic                   accept;
  logic                   hold_active;

  assign accept = (state_q == IDLE) && in_valid;
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = DIFF;
      DIFF:    state_d = UPDATE;
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: capture sample and coefficients; later control changes are ignored
  // Stage p1: direction and magnitude; larger operand is always the minuend
  always_ff @(posedge clk) begin
    if (accept) begin
      e_p0   <= in_energy;
      ash_p0 <= attack_shift;
      rsh_p0 <= release_shift;
    end
    if (state_q == DIFF) begin
      up_p1   <= (e_p0 > env_q);
      diff_p1 <= (e_p0 > env_q) ? (e_p0 - env_q) : (env_q - e_p0);
    end
  end

  // Stage p2: shift-based step toward the target
  assign shift_sel = up_p1 ? ash_p0 : rsh_p0;

  k_env_step #(
    .E_WIDTH     (E_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_step (
    .diff  (diff_p1),
    .shift (shift_sel),
    .step  (step)
  );

`ifdef K_ENV_PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

  logic [HOLD_W-1:0] hold_q;

  // Equality (diff == 0) leaves the counter alone.
  assign hold_active = !up_p1 && (diff_p1 != '0) && (hold_q != '0);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hold_q <= '0;
    end else if (state_q == UPDATE) begin
      if (up_p1)            hold_q <= HOLD_W'(HOLD_SAMPLES);
      else if (hold_active) hold_q <= hold_q - HOLD_W'(1);
    end
  end
`else
  assign hold_active = 1'b0;
`endif

  // Step never exceeds diff, so the envelope cannot overshoot the target.
  assign env_upd = hold_active ? env_q
                 : (up_p1 ? (env_q + step) : (env_q - step));

  // Stage p3: publish envelope with its valid pulse
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      env_q     <= '0;
      out_env   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      if (in_valid && (state_q != IDLE)) overrun <= 1'b1;
      if (state_q == UPDATE) env_q <= env_upd;
      if (state_q == DONE) begin
        out_env   <= env_q;
        out_valid <= 1'b1;
      end
    end
  end

endmodule : k_energy_envelope

// File: doc/k_energy_envelope.md
Name: k_energy_envelope

Overview:
- Downstream stage of the per-sample energy computer in the audio compressor IP.
- Consumes each energy value (re²+im²) with its one-cycle valid pulse.
- Produces a smoothed attack/release envelope using a one-pole shift-based filter, which feeds the gain-computation stage.
- Processes one sample per 4 cycles, matching the upstream minimum output spacing.

Parameters:
- E_WIDTH, 40, width of the input energy and the output envelope (unsigned).
- SHIFT_WIDTH, 4, width of the attack/release shift controls.
- HOLD_SAMPLES, 64, peak-hold length in accepted samples (used only with K_ENV_PEAK_HOLD_EN).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- in_energy  in  E_WIDTH  unsigned energy sample.
- in_valid  in  1  one-cycle qualifier for in_energy.
- attack_shift  in  SHIFT_WIDTH  attack coefficient exponent; step = diff >> attack_shift.
- release_shift  in  SHIFT_WIDTH  release coefficient exponent.
- out_env  out  E_WIDTH  current envelope, registered.
- out_valid  out  1  one-cycle pulse: out_env was just updated.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky flag: in_valid seen while busy.

Behaviour:
- Reset is asynchronous, active-low, and overrides everything, including mid-operation.
  - On reset: state=IDLE, out_env=0, out_valid=0, busy=0, overrun=0, hold counter=0.
  - A sample in flight at reset is discarded.
- State machine: IDLE -> DIFF -> UPDATE -> DONE -> IDLE.
- IDLE:
  - Accepts when in_valid=1 at a rising edge.
  - Captures in_energy, attack_shift and release_shift into internal registers.
  - Shift changes after capture do not affect the sample in flight.
- DIFF:
  - up = (e > env).
  - diff = up ? e-env : env-e, as an unsigned E_WIDTH subtraction with no wrap, because the larger operand is always the minuend.
- UPDATE:
  - shifted = diff >> (up ? attack_shift : release_shift).
  - step = (diff != 0 && shifted == 0) ? 1 : shifted. This minimum-step rule guarantees convergence.
  - env <= up ? env+step : env-step.
  - No saturation is needed; env never passes e.
  - e == env: env is unchanged.
- DONE:
  - out_valid=1 for exactly this cycle; returns to IDLE on the next edge.
- Timing: a sample accepted at edge k gives updated out_env and out_valid high from edge k+3 to edge k+4. The block is able to accept again at edge k+4.
- in_valid while busy: the sample is dropped and overrun is set to 1. The in-flight sample completes normally. overrun clears only on reset.
- Shift value 0 means step = diff, so the envelope tracks the input exactly. Shift >= E_WIDTH gives shifted=0, so step=1 whenever diff != 0.

Optional Feature:
- Macro: K_ENV_PEAK_HOLD_EN.
- Defined:
  - Each attack update (up=1) reloads the hold counter to HOLD_SAMPLES.
  - A release-direction sample with counter > 0 leaves env unchanged and decrements the counter. out_valid still pulses.
  - A release-direction sample with counter == 0 releases normally.
  - e == env does not touch the counter.
- Undefined:
  - No hold counter exists; release applies immediately.
  - HOLD_SAMPLES is ignored.

Decomposition:
- Shared package k_aud_cmprs_pkg holds:
  - the state encoding (IDLE=0, DIFF=1, UPDATE=2, DONE=3) as a 2-bit typedef;
  - the default E_WIDTH and SHIFT_WIDTH constants shared with the energy computer.
- One sub-module, k_env_step: combinational shift plus minimum-step-of-1 logic (inputs diff and shift; output step). It is reused by the later gain smoother.

Test Plan:
- Attack:
  - Stimulus: reset, attack_shift=2, release_shift=4; energy 1000, then 1000 again.
  - Required: out_env = 250, then 437; each out_valid pulse arrives exactly 3 edges after acceptance.
- Release:
  - Stimulus: from env=437, energy 0 twice.
  - Required: out_env = 410, then 385.
- Minimum step and equality:
  - Stimulus: env=10, attack_shift=4, energy 11, then 11 again.
  - Required: out_env = 11, then 11 unchanged; out_valid pulses both times.
- Overrun:
  - Stimulus: in_valid at edge k and at edge k+2.
  - Required: the second sample is ignored; out_env reflects only the first; overrun=1 and stays 1; busy is high at edges k+1 to k+3.
- Reset mid-operation:
  - Stimulus: assert aresetn=0 asynchronously while the block is in UPDATE.
  - Required: all outputs 0 immediately; no out_valid pulse; the next sample from env=0 behaves as in the first Attack step.
- Peak hold (K_ENV_PEAK_HOLD_EN, HOLD_SAMPLES=2):
  - Stimulus: attack to 250, then three samples of energy 0.
  - Required: out_env = 250, 250, then 235.
